// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Handshake and data bundle for the nibble-serial add/subtract sequencer.
// The requester and the consumer both sit on the master side.
interface nibble_serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         c_out;
  logic         ovf;
  logic         zero;
  logic         busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, c_out, ovf, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, c_out, ovf, zero, busy
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// W-bit two's-complement add/subtract computed one nibble per clock, LSB first,
// on a single shared 4-bit slice with the carry rippled through a register.
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  nibble_serial_addsub_ctrl_if.slave    bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);
  localparam logic [IDXW:0] LAST = (IDXW + 1)'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_result;
  logic            r_c_out;
  logic            r_ovf;
  logic            r_zero;
  logic            r_out_valid;
  logic            r_busy;
  logic            r_in_ready;

  logic [IDXW:0]   w_idx_ext;
  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_sum;
  logic            w_cy;
  logic [W-1:0]    w_result_next;
  logic            w_last;
  logic            w_idx_bad;
  logic            w_ovf;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_a_nib       = '0;
    w_b_nib       = '0;
    w_idx_ext     = {1'b0, r_idx};
    w_last        = (w_idx_ext == LAST);
    w_idx_bad     = (w_idx_ext > LAST);
    for (int i = 0; i < NIBBLES; i++) begin
      if (w_idx_ext == (IDXW + 1)'(i)) begin
        w_a_nib = r_a[i*4 +: 4];
        w_b_nib = r_b[i*4 +: 4];
      end
    end
    // Inverting b and seeding the carry with op turns the add into a - b.
    {w_cy, w_sum} = {1'b0, w_a_nib} + {1'b0, w_b_nib ^ {4{r_op}}} + {4'b0, r_carry};
    w_result_next = r_result;
    for (int i = 0; i < NIBBLES; i++) begin
      if (w_idx_ext == (IDXW + 1)'(i)) w_result_next[i*4 +: 4] = w_sum;
    end
    w_ovf = (r_a[W-1] == (r_b[W-1] ^ r_op)) && (w_sum[3] != r_a[W-1]);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_op        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_op       <= bus.op;
            r_carry    <= bus.op;
            r_idx      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_idx_bad) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end else begin
            r_result <= w_result_next;
            r_carry  <= w_cy;
            r_idx    <= r_idx + 1'b1;
            if (w_last) begin
              r_c_out     <= w_cy;
              r_ovf       <= w_ovf;
              r_zero      <= (w_result_next == '0);
              r_idx       <= '0;
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_idx       <= '0;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.c_out     = r_c_out;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.busy      = r_busy;
endmodule
